// File: rtl/fetch_unit.sv
// fetch_unit: program counter and run/halt sequencer with a saturating
// RUN-cycle counter. ProgCtr, Running, Done and CycleCount are all flops.
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic             AluLsb,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_next;

  // Next-state, next-PC and next-count decode; halt outranks a taken branch.
  always_comb begin
    state_next = state;
    pc_next    = ProgCtr;
    cnt_next   = CycleCount;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = START_PC;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (CycleCount != CNT_MAX) begin
          cnt_next = CycleCount + CNT_W'(1);
        end
        if (Halt) begin
          state_next = HALT;
        end else if (BranchEn && !AluLsb) begin
          pc_next = Target;
        end else begin
          pc_next = ProgCtr + PC_W'(1);
        end
      end
      HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = START_PC;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC, counter and status flags; reset clears everything immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      CycleCount <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_next;
      ProgCtr    <= pc_next;
      CycleCount <= cnt_next;
      Running    <= (state_next == RUN);
      Done       <= (state_next == HALT);
    end
  end

endmodule
